// File: rtl/tcm_ifetch_buf.sv
// tcm_ifetch_buf -- instruction prefetch buffer between the core fetch stage
// and the TCM instruction port.
//
// Issues sequential 64-bit fetches (pc += 8) and queues the returned words in
// a DEPTH-entry FIFO. A word is handed to the core through valid/accept.
// Responses that belong to fetches issued before a redirect are discarded.
//
// Optional feature: define TCM_IFETCH_BYPASS_EN to let a response reach
// fetch_*_o combinationally when the FIFO is empty. Without it, every response
// is registered in the FIFO first.
//
// Parameters
//   DEPTH     FIFO entries and max outstanding fetches (power of 2, >= 2)
//   RESET_PC  fetch start address after reset (bits [2:0] ignored)
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   branch_i/branch_pc_i  redirect pulse and target
//   fetch_*_o             FIFO head: valid, instruction, pc, fault
//   fetch_accept_i        core pops the head
//   mem_i_rd_o/mem_i_pc_o registered fetch request to the TCM
//   mem_i_accept_i        TCM takes the request
//   mem_i_valid_i/error_i/inst_i  in-order response from the TCM
module tcm_ifetch_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_i,
  input  logic [31:0] branch_pc_i,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_fault_o,
  input  logic        fetch_accept_i,
  output logic        mem_i_rd_o,
  output logic [31:0] mem_i_pc_o,
  input  logic        mem_i_accept_i,
  input  logic        mem_i_valid_i,
  input  logic        mem_i_error_i,
  input  logic [63:0] mem_i_inst_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [63:0]       fifo_instr [DEPTH];
  logic [31:0]       fifo_pc    [DEPTH];
  logic [DEPTH-1:0]  fifo_fault;
  logic [31:0]       pc_rec     [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr, iss_ptr, rsp_ptr;
  logic [CW-1:0] count_q, inflight_q, drop_q;
  logic [CW-1:0] count_d, inflight_d, drop_d;
  logic          halted_q, halted_d;
  logic          rd_q, rd_d;
  logic [31:0]   pc_q, pc_d;

  logic          issue_acc;
  logic          rsp_keep;
  logic          head_valid;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [31:0]   rsp_pc;
  logic          unused_branch_lsb;

  assign unused_branch_lsb = ^branch_pc_i[2:0];

  assign issue_acc  = rd_q & mem_i_accept_i;
  // A response is kept only when no stale fetches are still draining and no
  // redirect is happening this cycle.
  assign rsp_keep   = mem_i_valid_i & (drop_q == '0) & ~branch_i;
  // Responses return in order, so the response pointer selects the address
  // recorded when that fetch was accepted.
  assign rsp_pc     = pc_rec[rsp_ptr];
  assign head_valid = (count_q != '0);

`ifdef TCM_IFETCH_BYPASS_EN
  assign bypass        = rsp_keep & ~head_valid;
  assign fetch_valid_o = head_valid | bypass;
  assign fetch_instr_o = bypass ? mem_i_inst_i  : fifo_instr[rd_ptr];
  assign fetch_pc_o    = bypass ? rsp_pc        : fifo_pc[rd_ptr];
  assign fetch_fault_o = bypass ? mem_i_error_i : fifo_fault[rd_ptr];
`else
  assign bypass        = 1'b0;
  assign fetch_valid_o = head_valid;
  assign fetch_instr_o = fifo_instr[rd_ptr];
  assign fetch_pc_o    = fifo_pc[rd_ptr];
  assign fetch_fault_o = fifo_fault[rd_ptr];
`endif

  assign pop  = head_valid & fetch_accept_i & ~branch_i;
  // A bypassed word taken by the core in the same cycle never enters the FIFO.
  assign push = rsp_keep & ~(bypass & fetch_accept_i);

  assign mem_i_rd_o = rd_q;
  assign mem_i_pc_o = pc_q;

  always_comb begin
    inflight_d = inflight_q + CW'(issue_acc) - CW'(mem_i_valid_i);
    count_d    = count_q + CW'(push) - CW'(pop);
    drop_d     = drop_q;
    halted_d   = halted_q | (mem_i_valid_i & (drop_q == '0) & mem_i_error_i);
    pc_d       = issue_acc ? pc_q + 32'd8 : pc_q;
    if (mem_i_valid_i && drop_q != '0)
      drop_d = drop_q - CW'(1);
    if (branch_i) begin
      // Everything still outstanding after this cycle's updates is stale.
      count_d  = '0;
      drop_d   = inflight_d;
      halted_d = 1'b0;
      pc_d     = {branch_pc_i[31:3], 3'b000};
    end
    // Issue decision is made on next-cycle credits so the registered request
    // never oversubscribes the FIFO.
    rd_d = ~halted_d && (({1'b0, count_d} + {1'b0, inflight_d}) < DEPTH_C);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= {RESET_PC[31:3], 3'b000};
      rd_q       <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      iss_ptr    <= '0;
      rsp_ptr    <= '0;
      fifo_fault <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
        pc_rec[i]     <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      if (issue_acc) begin
        pc_rec[iss_ptr] <= pc_q;
        iss_ptr         <= iss_ptr + PW'(1);
      end
      if (mem_i_valid_i)
        rsp_ptr <= rsp_ptr + PW'(1);
      if (branch_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          fifo_instr[wr_ptr] <= mem_i_inst_i;
          fifo_pc[wr_ptr]    <= rsp_pc;
          fifo_fault[wr_ptr] <= mem_i_error_i;
          wr_ptr             <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Credit accounting must make a push into a full FIFO impossible.
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      assert (!(push && ({1'b0, count_q} == DEPTH_C)));
  end

endmodule
